// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. A single full-adder slice and a carry flop consume
// the operands LSB-first, one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             maj;

    assign s_bit = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign maj   = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + ~borrow: invert B and the incoming borrow.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = maj;
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                work_d  = {s_bit, work_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB; overflow is carry-in xor carry-out there.
                    sum_d   = {s_bit, work_q[WIDTH-1:1]};
                    cout_d  = maj;
                    ovf_d   = carry_q ^ maj;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic reference model with acceptance-time bookkeeping,
// checked every cycle, plus hand-computed results for the directed operations.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Hand-computed directed cases.
    int lit_a   [7] = '{'h3C, 'hFF, 'h7F, 'h05, 'h80, 'h10, 'h3C};
    int lit_b   [7] = '{'h0F, 'h01, 'h01, 'h07, 'h01, 'h00, 'h0F};
    int lit_c   [7] = '{0, 1, 0, 0, 0, 1, 0};
    int lit_s   [7] = '{0, 0, 0, 1, 1, 1, 0};
    int lit_sum [7] = '{'h4B, 'h01, 'h80, 'hFE, 'h7F, 'h0F, 'h4B};
    int lit_co  [7] = '{0, 1, 0, 0, 1, 1, 0};
    int lit_ov  [7] = '{0, 0, 1, 0, 1, 0, 0};

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Result of one operation from plain integer arithmetic.
    task automatic model_calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                              input logic sb, output logic [W-1:0] s, output logic co,
                              output logic ov);
        longint ux, uy, sx, sy, lc, full, sfull, smax, smin;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        lc = ci ? 64'sd1 : 64'sd0;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -smax - 1;
        if (sb) begin
            full  = ux - uy - lc;
            co    = (ux >= uy + lc);
            sfull = sx - sy - lc;
        end else begin
            full  = ux + uy + lc;
            co    = (full >= (longint'(1) <<< W));
            sfull = sx + sy + lc;
        end
        s  = full[W-1:0];
        ov = (sfull > smax) || (sfull < smin);
    endtask

    // Model: an accepted operation occupies the unit for W+2 cycles; busy for the W
    // cycles after acceptance, done in the cycle after that, results appear with done.
    int           cur_tag  = -1;
    int           k        = 0;
    int           acc_k    = 0;
    bit           acc_v    = 1'b0;
    logic [W-1:0] pend_sum = '0;
    logic         pend_co  = 1'b0;
    logic         pend_ov  = 1'b0;
    int           pend_tag = -1;
    logic [W-1:0] res_sum  = '0;
    logic         res_co   = 1'b0;
    logic         res_ov   = 1'b0;
    int           res_tag  = -1;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       = 0;
            acc_v   = 1'b0;
            res_sum = '0;
            res_co  = 1'b0;
            res_ov  = 1'b0;
            res_tag = -1;
        end else begin
            k++;
            if (acc_v && k == acc_k + W) begin
                res_sum = pend_sum;
                res_co  = pend_co;
                res_ov  = pend_ov;
                res_tag = pend_tag;
            end
            if (start && (!acc_v || k >= acc_k + W + 2)) begin
                acc_v    = 1'b1;
                acc_k    = k;
                pend_tag = cur_tag;
                model_calc(a, b, cin, sub, pend_sum, pend_co, pend_ov);
            end
        end
        exp_busy = acc_v && (k >= acc_k) && (k < acc_k + W);
        exp_done = acc_v && (k == acc_k + W);
    end

    always @(negedge clk) begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("sum",  sum,  res_sum);
        chk("cout", cout, res_co);
        chk("ovf",  ovf,  res_ov);
        if (exp_done && res_tag >= 0) begin
            chk("lit_sum_dut",   sum,     lit_sum[res_tag]);
            chk("lit_cout_dut",  cout,    lit_co[res_tag]);
            chk("lit_ovf_dut",   ovf,     lit_ov[res_tag]);
            chk("lit_sum_model", res_sum, lit_sum[res_tag]);
            chk("lit_cout_model", res_co, lit_co[res_tag]);
            chk("lit_ovf_model", res_ov,  lit_ov[res_tag]);
            $display("op tag=%0d a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
                     res_tag, lit_a[res_tag], lit_b[res_tag], lit_c[res_tag], lit_s[res_tag],
                     sum, cout, ovf);
        end
    end

    // Launch one operation and wait (bounded) for its done pulse. Optionally pokes
    // start with junk operands a few cycles into the shift phase.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic sb, input int tag, input bit poke,
                          output int lat, output int bcnt);
        @(posedge clk);
        #2;
        a = x; b = y; cin = ci; sub = sb; start = 1'b1; cur_tag = tag;
        @(posedge clk);
        #2;
        start = 1'b0; cur_tag = -1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        bcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (poke && lat == 3) begin
                a = W'($urandom); b = W'($urandom); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
    endtask

    int lat, bcnt, last, pulses, c;

    initial begin
        // Reset with random inputs toggling.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); start = 1'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Directed cases, first one with latency and busy-length checks.
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 0, 1'b0, lat, bcnt);
        chk("latency", lat, 9);
        chk("busy_len", bcnt, 8);
        $display("add 3C+0F latency=%0d busy_cycles=%0d", lat, bcnt);
        for (int t = 1; t < 6; t++) begin
            run_op(W'(lit_a[t]), W'(lit_b[t]), 1'(lit_c[t]), 1'(lit_s[t]), t, 1'b0, lat, bcnt);
        end

        // Start during SHIFT must be ignored.
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 0, 1'b1, lat, bcnt);
        chk("poke_latency", lat, 9);

        // Abort mid-operation.
        @(posedge clk);
        #2;
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum",  sum,  '0);
        $display("abort: busy=%0d done=%0d sum=%02h", busy, done, sum);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 6, 1'b0, lat, bcnt);

        // Back-to-back with start held high and operands changing every cycle.
        @(posedge clk);
        #2;
        start = 1'b1;
        last = -1;
        pulses = 0;
        c = 0;
        while (pulses < 3 && c < 60) begin
            @(negedge clk);
            c++;
            if (done) begin
                if (last >= 0) chk("b2b_gap", c - last, 10);
                $display("b2b pulse %0d at cycle %0d sum=%02h cout=%0d ovf=%0d", pulses, c, sum, cout, ovf);
                last = c;
                pulses++;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_pulses", pulses, 3);
        repeat (3) @(negedge clk);

        // Randomized operations with random gaps and occasional mid-shift pokes.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1,
                   1'($urandom_range(0, 3) == 0), lat, bcnt);
            $display("rand op %0d sum=%02h cout=%0d ovf=%0d latency=%0d", i, sum, cout, ovf, lat);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
